// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: one-word-per-cycle prefetcher into a small {pc, instr} queue.
// Redirects and reset flush the queue and any in-flight response.
module instr_fetch_unit #(
    parameter int INSTR_W = 25,
    parameter int PC_W    = 6,
    parameter int DEPTH   = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    output logic                         imem_req,
    output logic [PC_W-1:0]              imem_addr,
    input  logic [INSTR_W-1:0]           imem_rdata,
    input  logic                         redirect_valid,
    input  logic [PC_W-1:0]              redirect_pc,
    output logic                         instr_valid,
    input  logic                         instr_ready,
    output logic [INSTR_W-1:0]           instr_out,
    output logic [PC_W-1:0]              instr_pc,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W:0] DEPTH_V = (CNT_W+1)'(DEPTH);

    logic [PC_W-1:0]    fetch_pc_reg, fetch_pc_next;
    logic               inflight_reg, inflight_next;
    logic [PC_W-1:0]    inflight_pc_reg, inflight_pc_next;
    logic [PTR_W-1:0]   rd_ptr_reg, rd_ptr_next;
    logic [PTR_W-1:0]   wr_ptr_reg, wr_ptr_next;
    logic [CNT_W-1:0]   count_reg, count_next;

    logic [PC_W-1:0]    pc_mem    [DEPTH];
    logic [INSTR_W-1:0] instr_mem [DEPTH];

    logic [CNT_W:0]     occupancy;
    logic               push;
    logic               pop;

    // In-flight slot is reserved up front, so the queue can never overflow.
    assign occupancy   = {1'b0, count_reg} + {{CNT_W{1'b0}}, inflight_reg};
    assign imem_req    = reset && !redirect_valid && (occupancy < DEPTH_V);
    assign imem_addr   = reset ? fetch_pc_reg : '0;
    assign instr_valid = reset && (count_reg != '0);
    assign instr_out   = instr_valid ? instr_mem[rd_ptr_reg] : '0;
    assign instr_pc    = instr_valid ? pc_mem[rd_ptr_reg] : '0;
    assign count       = reset ? count_reg : '0;

    assign push = reset && inflight_reg && !redirect_valid;
    assign pop  = instr_valid && instr_ready && !redirect_valid;

    always_comb begin
        fetch_pc_next    = fetch_pc_reg;
        inflight_next    = imem_req;
        inflight_pc_next = fetch_pc_reg;
        rd_ptr_next      = rd_ptr_reg;
        wr_ptr_next      = wr_ptr_reg;
        count_next       = count_reg;
        if (redirect_valid) begin
            fetch_pc_next = redirect_pc;
            rd_ptr_next   = '0;
            wr_ptr_next   = '0;
            count_next    = '0;
        end else begin
            if (imem_req) begin
                fetch_pc_next = fetch_pc_reg + PC_W'(1);
            end
            if (push) begin
                wr_ptr_next = wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_next = rd_ptr_reg + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_next = count_reg + CNT_W'(1);
                2'b01:   count_next = count_reg - CNT_W'(1);
                default: count_next = count_reg;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            fetch_pc_reg    <= '0;
            inflight_reg    <= 1'b0;
            inflight_pc_reg <= '0;
            rd_ptr_reg      <= '0;
            wr_ptr_reg      <= '0;
            count_reg       <= '0;
        end else begin
            fetch_pc_reg    <= fetch_pc_next;
            inflight_reg    <= inflight_next;
            inflight_pc_reg <= inflight_pc_next;
            rd_ptr_reg      <= rd_ptr_next;
            wr_ptr_reg      <= wr_ptr_next;
            count_reg       <= count_next;
        end
    end

    // Queue storage carries no reset; validity is tracked by count_reg alone.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr_reg]    <= inflight_pc_reg;
            instr_mem[wr_ptr_reg] <= imem_rdata;
        end
    end

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter INSTR_W, default 25, instruction width in bits.
REQ-002 Parameter PC_W, default 6, program-counter width in bits; the address space is 2^PC_W words.
REQ-003 Parameter DEPTH, default 4, prefetch queue depth; must be a power of two and >= 2.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 reset  input  1  synchronous, active-low reset (0 = reset asserted).
REQ-006 imem_req  output  1  read request to instruction memory this cycle.
REQ-007 imem_addr  output  PC_W  word address of the request.
REQ-008 imem_rdata  input  INSTR_W  read data, valid exactly one cycle after imem_req was high.
REQ-009 redirect_valid  input  1  flush the queue and restart fetch at redirect_pc.
REQ-010 redirect_pc  input  PC_W  restart address.
REQ-011 instr_valid  output  1  queue head holds an instruction.
REQ-012 instr_ready  input  1  consumer accepts the head this cycle.
REQ-013 instr_out  output  INSTR_W  head instruction; 0 when instr_valid is 0.
REQ-014 instr_pc  output  PC_W  address of the head instruction; 0 when instr_valid is 0.
REQ-015 count  output  clog2(DEPTH+1)  number of queued entries.

Function
REQ-016 State: fetch_pc (PC_W bits), one in-flight flag, a DEPTH-entry FIFO of {pc, instr} pairs, and a count.
REQ-017 imem_req = reset && !redirect_valid && (count + inflight < DEPTH); the pop in the same cycle is ignored, so the check is conservative.
REQ-018 imem_addr = fetch_pc at all times; each cycle with imem_req=1 sets fetch_pc <= fetch_pc+1 (modulo 2^PC_W) and inflight <= 1; otherwise inflight <= 0.
REQ-019 PC wrap: 2^PC_W-1 increments to 0 with no error and no gap.
REQ-020 Response: in a cycle with inflight=1 and no redirect, {pc of request, imem_rdata} is pushed at the tail.
REQ-021 Pop: instr_valid && instr_ready removes the head on that edge.
REQ-022 Simultaneous push and pop: both occur; count is unchanged.
REQ-023 The FIFO never overflows; a push when count=DEPTH is impossible by REQ-017.
REQ-024 Output is taken from FIFO storage only, with no bypass; minimum latency from request to instr_valid is 2 cycles.
REQ-025 Hold: while instr_valid=1 and instr_ready=0, instr_out and instr_pc remain stable unless a redirect occurs.
REQ-026 Redirect cycle: no request is issued; any inflight response is discarded; the FIFO is emptied (count <= 0); fetch_pc <= redirect_pc.
REQ-027 Redirect is highest priority over push and pop.
REQ-028 A head handshaken in the redirect cycle counts as consumed.
REQ-029 After a redirect, instr_valid is 0 in the next cycle; the first request at redirect_pc issues in that same next cycle.
REQ-030 Back-to-back redirects: only the last redirect takes effect.
REQ-031 Sustained throughput with instr_ready held at 1 is one instruction per cycle.

Reset
REQ-032 While reset=0 at an edge: fetch_pc <= 0, inflight <= 0, FIFO emptied, count <= 0.
REQ-033 While reset=0: imem_req=0, imem_addr=0, instr_valid=0, instr_out=0, instr_pc=0, count=0.
REQ-034 Reset mid-operation discards all queued and inflight data; any imem_rdata returned after reset is ignored.
REQ-035 Fetch restarts at address 0 in the first cycle with reset=1.

Verification
REQ-036 Cold start: mem[k]=k+100, instr_ready=1. Release reset at cycle 0 -> imem_req=1 with addr 0 at cycle 0; instr_valid=1 with instr_out=100 and instr_pc=0 at cycle 2; then one instruction per cycle, in order.
REQ-037 Backpressure: hold instr_ready=0 -> count saturates at 4, imem_req=0, and instr_out stays 100. Raise instr_ready -> pcs 0,1,2,... are delivered with no gap or duplicate.
REQ-038 Redirect: pulse redirect_valid with redirect_pc=40 while count=3 and inflight=1 -> next cycle count=0, instr_valid=0, imem_addr=40. The next delivered instruction has instr_pc=40; no stale pc is ever delivered.
REQ-039 Wrap (PC_W=6): redirect to 62 -> delivered pcs are 62, 63, 0, 1.
REQ-040 Reset mid-stream with count=2 -> all outputs are 0 during reset; after release the first delivered instr_pc=0.
REQ-041 Simultaneous redirect, handshake, and inflight response in one cycle -> count=0 next cycle; the response and the queued entries are dropped.
